// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage and its alignment helper.
package mem_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NBYTES   = XLEN / 8;
    localparam int unsigned RF_AW    = 5;
    localparam int unsigned WBSEL_W  = 2;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned OFF_W    = 2;

    // RISC-V load/store funct3 encodings
    localparam logic [FUNCT3_W-1:0] MASK_B  = 3'b000;
    localparam logic [FUNCT3_W-1:0] MASK_H  = 3'b001;
    localparam logic [FUNCT3_W-1:0] MASK_W  = 3'b010;
    localparam logic [FUNCT3_W-1:0] MASK_BU = 3'b100;
    localparam logic [FUNCT3_W-1:0] MASK_HU = 3'b101;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_RSP = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic                reg_wr;
        logic [WBSEL_W-1:0]  sel_wb;
        logic [RF_AW-1:0]    rd;
        logic [XLEN-1:0]     alu_o;
        logic [XLEN-1:0]     pc4;
        logic [XLEN-1:0]     ld_data;
    } memwb_t;

    // Word-aligned address of the access
    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:OFF_W], OFF_W'(0)};
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus: one outstanding request, separate grant and response.
interface mem_stage_if;
    import mem_pkg::*;

    logic                req;
    logic                we;
    logic [XLEN-1:0]     addr;
    logic [NBYTES-1:0]   be;
    logic [XLEN-1:0]     wdata;
    logic                gnt;
    logic                rvalid;
    logic [XLEN-1:0]     rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational load/store alignment: byte enables, store lane replication,
// load extract/extend, and misaligned/illegal-width detection.
module lsu_align
    import mem_pkg::*;
(
    input  logic [FUNCT3_W-1:0] mask,
    input  logic [OFF_W-1:0]    off,
    input  logic [XLEN-1:0]     wr_data,
    input  logic [XLEN-1:0]     rdata,
    output logic [NBYTES-1:0]   be,
    output logic [XLEN-1:0]     wdata,
    output logic [XLEN-1:0]     ld_data,
    output logic                misalign
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Halfword lanes only ever start at byte 0 or 2 once alignment holds
    assign ld_byte = rdata[{off, 3'b000} +: 8];
    assign ld_half = rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        be       = '0;
        wdata    = wr_data;
        ld_data  = rdata;
        misalign = 1'b0;
        case (mask)
            MASK_B, MASK_BU: begin
                be      = NBYTES'(4'b0001 << off);
                wdata   = {4{wr_data[7:0]}};
                ld_data = (mask == MASK_B) ? {{24{ld_byte[7]}}, ld_byte}
                                           : {24'd0, ld_byte};
            end
            MASK_H, MASK_HU: begin
                misalign = off[0];
                be       = off[0] ? '0 : NBYTES'(4'b0011 << off);
                wdata    = {2{wr_data[15:0]}};
                ld_data  = (mask == MASK_H) ? {{16{ld_half[15]}}, ld_half}
                                            : {16'd0, ld_half};
            end
            MASK_W: begin
                misalign = (off != '0);
                be       = (off != '0) ? '0 : '1;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues one data-memory transaction per
// load/store, stalls upstream while it is outstanding, and owns MEM/WB.
module mem_stage
    import mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst,

    input  logic                reg_wr_M,
    input  logic                mem_wr_M,
    input  logic                mem_rd_M,
    input  logic [FUNCT3_W-1:0] mem_mask_M,
    input  logic [WBSEL_W-1:0]  sel_wb_M,
    input  logic [XLEN-1:0]     alu_o_M,
    input  logic [XLEN-1:0]     wr_data_M,
    input  logic [RF_AW-1:0]    rd_M,
    input  logic [XLEN-1:0]     PC4_M,

    mem_stage_if.master         dmem,

    output logic                stall_M,
    output logic                misalign_M,

    output logic                reg_wr_W,
    output logic [WBSEL_W-1:0]  sel_wb_W,
    output logic [RF_AW-1:0]    rd_W,
    output logic [XLEN-1:0]     alu_o_W,
    output logic [XLEN-1:0]     PC4_W,
    output logic [XLEN-1:0]     ld_data_W
);

    mem_state_t        state_q, state_d;
    memwb_t            wb_q, wb_d;

    logic [NBYTES-1:0] al_be;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_ld;
    logic              al_mis;

    logic              access;
    logic              bad_access;
    logic              go;

    logic              req;
    logic              we;
    logic [NBYTES-1:0] be;
    logic              stall;
    logic              mis;

    lsu_align u_align (
        .mask     (mem_mask_M),
        .off      (alu_o_M[OFF_W-1:0]),
        .wr_data  (wr_data_M),
        .rdata    (dmem.rdata),
        .be       (al_be),
        .wdata    (al_wdata),
        .ld_data  (al_ld),
        .misalign (al_mis)
    );

    assign access     = mem_rd_M | mem_wr_M;
    assign bad_access = access & al_mis;
    assign go         = access & ~al_mis;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: loads wait for their response, stores finish on grant
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (go && mem_rd_M && dmem.gnt) begin
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (dmem.rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic; everything is forced quiet while reset is asserted
    always_comb begin
        req   = 1'b0;
        we    = 1'b0;
        be    = '0;
        stall = 1'b0;
        mis   = 1'b0;
        if (!rst) begin
            mis = bad_access;
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        req   = 1'b1;
                        we    = mem_wr_M;
                        be    = al_be;
                        stall = mem_rd_M | ~dmem.gnt;
                    end
                end
                ST_WAIT_RSP: begin
                    stall = ~dmem.rvalid;
                end
                default: ;
            endcase
        end
    end

    assign dmem.req   = req;
    assign dmem.we    = we;
    assign dmem.be    = be;
    assign dmem.addr  = word_addr(alu_o_M);
    assign dmem.wdata = al_wdata;
    assign stall_M    = stall;
    assign misalign_M = mis;

    // MEM/WB payload: bubble while stalled or when the access is rejected
    always_comb begin
        wb_d = '0;
        if (!stall && !bad_access) begin
            wb_d.reg_wr  = reg_wr_M;
            wb_d.sel_wb  = sel_wb_M;
            wb_d.rd      = rd_M;
            wb_d.alu_o   = alu_o_M;
            wb_d.pc4     = PC4_M;
            wb_d.ld_data = mem_rd_M ? al_ld : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign reg_wr_W  = wb_q.reg_wr;
    assign sel_wb_W  = wb_q.sel_wb;
    assign rd_W      = wb_q.rd;
    assign alu_o_W   = wb_q.alu_o;
    assign PC4_W     = wb_q.pc4;
    assign ld_data_W = wb_q.ld_data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized transactions
// compared against a transaction-level reference model.
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wr_M, mem_wr_M, mem_rd_M;
    logic [2:0]  mem_mask_M;
    logic [1:0]  sel_wb_M;
    logic [31:0] alu_o_M, wr_data_M, PC4_M;
    logic [4:0]  rd_M;
    logic        stall_M, misalign_M;
    logic        reg_wr_W;
    logic [1:0]  sel_wb_W;
    logic [4:0]  rd_W;
    logic [31:0] alu_o_W, PC4_W, ld_data_W;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_stage_if bus ();

    mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .reg_wr_M   (reg_wr_M),
        .mem_wr_M   (mem_wr_M),
        .mem_rd_M   (mem_rd_M),
        .mem_mask_M (mem_mask_M),
        .sel_wb_M   (sel_wb_M),
        .alu_o_M    (alu_o_M),
        .wr_data_M  (wr_data_M),
        .rd_M       (rd_M),
        .PC4_M      (PC4_M),
        .dmem       (bus),
        .stall_M    (stall_M),
        .misalign_M (misalign_M),
        .reg_wr_W   (reg_wr_W),
        .sel_wb_W   (sel_wb_W),
        .rd_W       (rd_W),
        .alu_o_W    (alu_o_W),
        .PC4_W      (PC4_W),
        .ld_data_W  (ld_data_W)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Access size in bytes; 0 marks an illegal funct3
    function automatic int unsigned m_size(input logic [2:0] m);
        case (m)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] m, input logic [31:0] wd);
        int unsigned s = m_size(m);
        if (s == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (s == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] m, input logic [31:0] a);
        int unsigned s = m_size(m);
        int unsigned v = ((1 << s) - 1) << (a % 4);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] m, input logic [31:0] a,
                                           input logic [31:0] rdat);
        int unsigned s = m_size(m);
        logic [31:0] v = rdat >> (8 * (a % 4));
        if (s == 1) begin
            v = v & 32'hFF;
            if (m == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (s == 2) begin
            v = v & 32'hFFFF;
            if (m == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic drive_nop();
        reg_wr_M = 0; mem_wr_M = 0; mem_rd_M = 0; mem_mask_M = 3'd2;
        sel_wb_M = 0; alu_o_M = 0; wr_data_M = 0; rd_M = 0; PC4_M = 0;
    endtask

    // One instruction through M: gd = cycles before grant, rvd = cycles from grant to rvalid
    task automatic run_txn(input string tag, input logic ld, input logic st, input logic regwr,
                           input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdat, input logic [4:0] rdst, input logic [1:0] sel,
                           input logic [31:0] pc4, input int gd, input int rvd,
                           output int stalls, output logic [31:0] o_addr,
                           output logic [3:0] o_be, output logic [31:0] o_wdata,
                           output logic o_mis);
        logic        mem, mis, legal, done, exp_req;
        int unsigned sz;
        int          exp_stall, bus_bad, bubble_bad;
        mem   = ld | st;
        sz    = m_size(m);
        mis   = mem && (sz == 0 || (a % sz) != 0);
        legal = mem && !mis;
        exp_stall = !legal ? 0 : (ld ? gd + rvd : gd);
        reg_wr_M = regwr; mem_wr_M = st; mem_rd_M = ld; mem_mask_M = m;
        sel_wb_M = sel; alu_o_M = a; wr_data_M = wd; rd_M = rdst; PC4_M = pc4;
        stalls = 0; bus_bad = 0; bubble_bad = 0; done = 0;
        o_addr = 0; o_be = 0; o_wdata = 0; o_mis = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            bus.gnt    = legal && c == gd;
            bus.rvalid = (legal && ld && c == gd + rvd) || (!legal && $urandom_range(0, 1) == 1);
            bus.rdata  = (legal && ld && c == gd + rvd) ? rdat : $urandom();
            #1;
            if (c == 0) begin
                o_addr = bus.addr; o_be = bus.be; o_wdata = bus.wdata; o_mis = misalign_M;
            end
            exp_req = legal && c <= gd;
            if (bus.req !== exp_req) bus_bad++;
            if (misalign_M !== mis) bus_bad++;
            if (exp_req) begin
                if (bus.we !== st) bus_bad++;
                if (bus.addr !== (a & 32'hFFFF_FFFC)) bus_bad++;
                if (bus.be !== m_be(m, a)) bus_bad++;
                if (st && bus.wdata !== m_wdata(m, wd)) bus_bad++;
            end
            if (stall_M === 1'b1) begin
                stalls++;
                @(posedge clk); #1;
                if (reg_wr_W !== 0 || rd_W !== 0 || ld_data_W !== 0) bubble_bad++;
            end else begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        bus.gnt = 0; bus.rvalid = 0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stall));
        check({tag, "_bus"}, 32'(bus_bad), 32'd0);
        check({tag, "_bubble"}, 32'(bubble_bad), 32'd0);
        check({tag, "_reg_wr_W"}, 32'(reg_wr_W), mis ? 32'd0 : 32'(regwr));
        check({tag, "_rd_W"}, 32'(rd_W), mis ? 32'd0 : 32'(rdst));
        check({tag, "_sel_wb_W"}, 32'(sel_wb_W), mis ? 32'd0 : 32'(sel));
        check({tag, "_alu_o_W"}, alu_o_W, mis ? 32'd0 : a);
        check({tag, "_PC4_W"}, PC4_W, mis ? 32'd0 : pc4);
        check({tag, "_ld_data_W"}, ld_data_W, (legal && ld) ? m_load(m, a, rdat) : 32'd0);
    endtask

    initial begin
        int          st_n;
        logic [31:0] o_addr, o_wdata;
        logic [3:0]  o_be;
        logic        o_mis;

        bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0;
        drive_nop();
        rst = 1;

        // Outputs must stay quiet under reset even with a legal load presented
        mem_rd_M = 1; reg_wr_M = 1; mem_mask_M = 3'd2; alu_o_M = 32'h100; bus.gnt = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(bus.req), 0);
        check("rst_stall", 32'(stall_M), 0);
        check("rst_be", 32'(bus.be), 0);
        check("rst_we", 32'(bus.we), 0);
        alu_o_M = 32'h102;
        #1;
        check("rst_misalign", 32'(misalign_M), 0);
        check("rst_W", {reg_wr_W, rd_W, sel_wb_W} | alu_o_W | PC4_W | ld_data_W, 0);
        @(posedge clk); #1;
        bus.gnt = 0;
        drive_nop();
        rst = 0;
        @(posedge clk); #1;

        run_txn("sw", 0, 1, 0, MASK_W, 32'h100, 32'hDEAD_BEEF, 0, 5'd0, 2'd0, 32'h1004,
                0, 1, st_n, o_addr, o_be, o_wdata, o_mis);
        check("sw_stall0", 32'(st_n), 0);
        check("sw_be", 32'(o_be), 32'hF);
        check("sw_wdata", o_wdata, 32'hDEAD_BEEF);
        check("sw_regwr", 32'(reg_wr_W), 0);

        run_txn("sb", 0, 1, 0, MASK_B, 32'h103, 32'h0000_00A5, 0, 5'd0, 2'd0, 32'h1008,
                0, 1, st_n, o_addr, o_be, o_wdata, o_mis);
        check("sb_be", 32'(o_be), 32'h8);
        check("sb_wdata", o_wdata, 32'hA5A5_A5A5);
        check("sb_addr", o_addr, 32'h100);

        run_txn("lb", 1, 0, 1, MASK_B, 32'h101, 0, 32'h0000_80FF, 5'd7, 2'd1, 32'h100C,
                0, 1, st_n, o_addr, o_be, o_wdata, o_mis);
        check("lb_stall1", 32'(st_n), 1);
        check("lb_data", ld_data_W, 32'hFFFF_FF80);

        run_txn("lbu", 1, 0, 1, MASK_BU, 32'h101, 0, 32'h0000_80FF, 5'd8, 2'd1, 32'h1010,
                0, 1, st_n, o_addr, o_be, o_wdata, o_mis);
        check("lbu_data", ld_data_W, 32'h0000_0080);

        run_txn("lh", 1, 0, 1, MASK_H, 32'h102, 0, 32'h7FFF_0000, 5'd9, 2'd1, 32'h1014,
                2, 3, st_n, o_addr, o_be, o_wdata, o_mis);
        check("lh_stall5", 32'(st_n), 5);
        check("lh_data", ld_data_W, 32'h0000_7FFF);

        run_txn("lw_mis", 1, 0, 1, MASK_W, 32'h102, 0, 32'h1234_5678, 5'd10, 2'd1, 32'h1018,
                0, 1, st_n, o_addr, o_be, o_wdata, o_mis);
        check("lw_mis_flag", 32'(o_mis), 1);
        check("lw_mis_nostall", 32'(st_n), 0);
        check("lw_mis_regwr", 32'(reg_wr_W), 0);

        // Asynchronous reset while a load waits for its response
        reg_wr_M = 1; mem_rd_M = 1; mem_wr_M = 0; mem_mask_M = MASK_W; alu_o_M = 32'h200;
        rd_M = 5'd3; bus.gnt = 1;
        @(posedge clk); #1;
        bus.gnt = 0;
        #2 rst = 1;
        #1;
        check("mid_rst_stall", 32'(stall_M), 0);
        check("mid_rst_req", 32'(bus.req), 0);
        check("mid_rst_W", 32'(reg_wr_W) | ld_data_W | 32'(rd_W), 0);
        #2 rst = 0;
        drive_nop();
        bus.rvalid = 1; bus.rdata = 32'hCAFE_F00D;
        #1;
        check("late_rv_stall", 32'(stall_M), 0);
        check("late_rv_req", 32'(bus.req), 0);
        @(posedge clk); #1;
        bus.rvalid = 0;
        check("late_rv_ld", ld_data_W, 0);
        run_txn("post_rst_lw", 1, 0, 1, MASK_W, 32'h204, 0, 32'h89AB_CDEF, 5'd4, 2'd1, 32'h2000,
                0, 1, st_n, o_addr, o_be, o_wdata, o_mis);

        // Randomized mix of ALU ops, loads, stores, illegal widths and bus delays
        for (int i = 0; i < 80; i++) begin
            logic [2:0]  m;
            int          kind, sel_m;
            logic        ld, st;
            sel_m = $urandom_range(0, 9);
            case (sel_m)
                0, 1:    m = 3'd0;
                2:       m = 3'd1;
                3, 4:    m = 3'd2;
                5:       m = 3'd4;
                6:       m = 3'd5;
                7:       m = 3'd3;
                8:       m = 3'd6;
                default: m = 3'd7;
            endcase
            kind = $urandom_range(0, 4);
            ld = (kind == 1 || kind == 2);
            st = (kind == 3 || kind == 4);
            run_txn("rnd", ld, st, 1'($urandom_range(0, 1)), m, $urandom(), $urandom(),
                    $urandom(), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), $urandom(),
                    $urandom_range(0, 3), $urandom_range(1, 3),
                    st_n, o_addr, o_be, o_wdata, o_mis);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the EX/MEM pipeline register and writeback. Consumes the registered M-stage signals, runs one data-memory transaction per load/store over a req/gnt/rvalid bus, aligns store data and extracts/sign-extends load data, and owns the MEM/WB register. While an access is outstanding it raises `stall_M` so upstream stages hold.

## Interface
- No parameters. Datapath fixed at 32 bits; single outstanding transaction.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `reg_wr_M`, `mem_wr_M`, `mem_rd_M` in 1 each: M-stage controls; `mem_rd_M`/`mem_wr_M` never both 1.
- `mem_mask_M` in 3: RISC-V funct3. 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal.
- `sel_wb_M` in 2: writeback select, passed through.
- `alu_o_M` in 32: effective address or ALU result.
- `wr_data_M` in 32: store data, right-justified.
- `rd_M` in 5: destination register.
- `PC4_M` in 32: PC+4, passed through.
- `dmem_req` out 1: request valid.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out 32: `{alu_o_M[31:2],2'b00}`.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_gnt` in 1: request accepted this cycle.
- `dmem_rvalid` in 1: load data valid; never in the same cycle as its `gnt`.
- `dmem_rdata` in 32: load word.
- `stall_M` out 1: hold IF..EX/MEM this cycle.
- `misalign_M` out 1: current M-stage access is misaligned or illegal.
- `reg_wr_W`, `sel_wb_W`, `rd_W`, `alu_o_W`, `PC4_W`, `ld_data_W` out: MEM/WB register.

## Operation
- FSM states: IDLE, WAIT_RSP.
- **IDLE**, with a legal access (`mem_rd_M|mem_wr_M`, aligned, legal mask):
  - Drive `dmem_req=1`.
  - Store: completes on `gnt`. Stay IDLE; `stall_M=!gnt`.
  - Load: on `gnt`, go to WAIT_RSP; `stall_M=1`.
  - No `gnt`: hold the request with stable address/data/be; `stall_M=1`.
- **WAIT_RSP**:
  - `dmem_req=0`.
  - Until `rvalid`: `stall_M=1`.
  - On `rvalid`: `stall_M=0`, capture formatted data into `ld_data_W`, go to IDLE.
- Non-memory instruction in IDLE: `dmem_req=0`, `stall_M=0`.
- `dmem_rvalid` in IDLE is ignored, for example a stale response after reset.
- Misaligned access: H/HU with `off[0]=1`, or W with `off!=0`, where `off=alu_o_M[1:0]`. The illegal-mask rule is identical:
  - `misalign_M=1`, no request, `stall_M=0`.
  - W register captures a bubble (`reg_wr_W=0`).
- Store formatting:
  - B: `wdata={4{wr_data_M[7:0]}}`, `be=4'b0001<<off`.
  - H: `wdata={2{wr_data_M[15:0]}}`, `be=4'b0011<<off`.
  - W: `be=4'b1111`.
- Load extract: byte `rdata[8*off+:8]` or half `rdata[8*off+:16]`. Sign-extend for B/H, zero-extend for BU/HU, pass word unchanged.
- MEM/WB register:
  - When `stall_M=0`, capture the M-stage fields; `ld_data_W` takes formatted data for loads and 0 otherwise.
  - When `stall_M=1`, capture a bubble (all W outputs 0).

## Timing
- Reset values: state IDLE; all W outputs 0. Combinational outputs `dmem_req`, `dmem_we`, `dmem_be`, `stall_M` and `misalign_M` are 0 while `rst` is high.
- Zero-wait memory (`gnt` with `req`, `rvalid` the next cycle):
  - Load: 1 stall cycle; data appears on `ld_data_W` 2 edges after the load enters M.
  - Store: 0 stall cycles; the W bubble is not needed.
- Each extra cycle of `gnt` or `rvalid` delay adds exactly one stall cycle.
- Reset mid-transaction (IDLE or WAIT_RSP): immediately return to IDLE, drop the request, and ignore any late `rvalid`.
- `stall_M` is combinational from state, `gnt`, `rvalid` and the M inputs. There is no path from `stall_M` back into these inputs.

## Structure
- Shared package `mem_pkg`:
  - mask localparams `MASK_B/H/W/BU/HU`;
  - `mem_state_t` enum;
  - `memwb_t` packed struct for the W register.
- Sub-module `lsu_align` (combinational), holding `be`/`wdata` generation, load extract/extend, and misalign/illegal detection. It is reused by any future cache front-end.

## Test plan
- SW, `alu_o=0x100`, `wr_data=0xDEADBEEF`, zero-wait → `req`, `we=1`, `be=1111`, `wdata=0xDEADBEEF`, `stall_M` never 1, `reg_wr_W=0`.
- SB, `alu_o=0x103`, `wr_data=0x000000A5` → `be=1000`, `wdata=0xA5A5A5A5`, `addr=0x100`.
- LB at `0x101`, `rdata=0x0000_80FF` returned the cycle after `gnt` → exactly 1 stall cycle, `ld_data_W=0xFFFFFF80`. Repeat with LBU → `0x00000080`.
- LH at `0x102`, `gnt` delayed 2 cycles, `rvalid` 3 cycles later, `rdata=0x7FFF_0000` → 5 stall cycles, request held stable, W bubbles meanwhile, `ld_data_W=0x00007FFF`.
- LW at `0x102` → `misalign_M=1`, no `req`, no stall, `reg_wr_W=0`.
- Load in WAIT_RSP, `rst` pulsed asynchronously mid-cycle, then `rvalid=1` → state IDLE, W outputs 0, `rvalid` ignored, `stall_M=0`.
